// File: rtl/prf_free_list.sv
// Free list of physical register tags for rename: FIFO allocation and commit-time recycling,
// plus a one-tag-per-cycle scan that rebuilds the pool from the committed map after a flush.
module prf_free_list #(
  parameter int unsigned NumArch = 8,
  parameter int unsigned NumPrf  = 16,
  parameter int unsigned TagW    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alloc_req_i,
  output logic            alloc_valid_o,
  output logic [TagW-1:0] alloc_tag_o,
  input  logic            release_valid_i,
  input  logic [TagW-1:0] release_tag_i,
  input  logic            stop_i,
  input  logic [TagW-1:0] arf_tag_i [NumArch],
  output logic            ready_o,
  output logic [TagW:0]   free_count_o,
  output logic            err_overflow_o
);

  typedef enum logic [0:0] {StRun, StRecover} state_e;

  state_e              state_q, state_d;
  logic [TagW-1:0]     fifo_q [NumPrf];
  logic [TagW-1:0]     head_q, head_d, tail_q, tail_d, scan_q, scan_d;
  logic [TagW:0]       count_q, count_d;
  logic [NumPrf-1:0]   used_q, used_d, used_sample;
  logic                err_q, err_d;
  logic                wr_en, pop, push, full;
  logic [TagW-1:0]     wr_data;

  function automatic logic [TagW-1:0] ptr_inc(input logic [TagW-1:0] p);
    return (p == TagW'(NumPrf - 1)) ? '0 : p + 1'b1;
  endfunction

  // Duplicate tags in the committed map simply set the same bit twice.
  always_comb begin
    used_sample = '0;
    for (int i = 0; i < int'(NumArch); i++) used_sample[arf_tag_i[i]] = 1'b1;
  end

  assign ready_o        = (state_q == StRun);
  assign alloc_valid_o  = ready_o && (count_q != '0);
  assign alloc_tag_o    = fifo_q[head_q];
  assign free_count_o   = count_q;
  assign err_overflow_o = err_q;
  assign full           = (count_q == (TagW + 1)'(NumPrf));
  assign pop            = alloc_req_i && alloc_valid_o;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    scan_d  = scan_q;
    used_d  = used_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    push    = 1'b0;
    wr_data = release_tag_i;
    if (stop_i) begin
      used_d  = used_sample;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      scan_d  = '0;
      state_d = StRecover;
    end else begin
      unique case (state_q)
        StRun: begin
          // A same-cycle pop frees a slot, so a full FIFO can still accept the release.
          if (release_valid_i) begin
            if (full && !pop) err_d = 1'b1;
            else              push  = 1'b1;
          end
          if (pop) head_d = ptr_inc(head_q);
          if (push) begin
            wr_en  = 1'b1;
            tail_d = ptr_inc(tail_q);
          end
          count_d = count_q + (TagW + 1)'(push) - (TagW + 1)'(pop);
        end
        StRecover: begin
          if (!used_q[scan_q]) begin
            wr_en   = 1'b1;
            wr_data = scan_q;
            tail_d  = ptr_inc(tail_q);
            count_d = count_q + 1'b1;
          end
          scan_d = scan_q + 1'b1;
          if (scan_q == TagW'(NumPrf - 1)) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StRun;
      head_q  <= '0;
      tail_q  <= TagW'(NumPrf - NumArch);
      count_q <= (TagW + 1)'(NumPrf - NumArch);
      scan_q  <= '0;
      used_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(NumPrf); i++) begin
        fifo_q[i] <= (i < int'(NumPrf - NumArch)) ? TagW'(i + int'(NumArch)) : '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      scan_q  <= scan_d;
      used_q  <= used_d;
      err_q   <= err_d;
      if (wr_en) fifo_q[tail_q] <= wr_data;
    end
  end

endmodule
